axi_dw_upsizer: RTL and testbench
=================================

# axi_dw_upsizer

AXI4 data-width upsizer bridging a narrow slave port (64-bit default) to a wide master port (128-bit default). It places every narrow W beat into the correct wide byte lane and extracts every narrow R beat from the correct wide byte lane. Burst length, size, IDs and responses pass through unchanged; no beat merging is performed. It sits between a narrow AXI master and a wider interconnect or memory.

## Interface
- AXI_MAX_READS, 4: maximum outstanding read bursts; each must have a distinct ID.
- AXI_ADDR_WIDTH, 64: address width on both ports.
- AXI_ID_WIDTH, 4: ID width on both ports.
- AXI_SLV_PORT_DATA_WIDTH, 64: narrow data width, slave port.
- AXI_MST_PORT_DATA_WIDTH, 128: wide data width, master port. Must be a power-of-2 multiple of the narrow width.
- AXI_USER_WIDTH, 8: user width on all channels.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-high.
- slv  AXI_BUS slave modport  SLV data width  narrow port, driven by the upstream master.
- mst  AXI_BUS master modport  MST data width  wide port, drives the downstream slave.

## Operation
- Definitions:
  - SB = SLV bytes.
  - MB = MST bytes.
  - lane(addr) = addr[log2(MB)-1 : log2(SB)].
- AW, AR: all fields forwarded unchanged (addr, len, size, burst, id, lock, cache, prot, qos, region, atop, user).
- ax_size > log2(SB) is illegal. Upstream must not issue it; behaviour is undefined.
- Write tracking: one write burst in flight on W.
  - Accept AW only when the write tracker is idle.
  - On AW handshake, latch addr, size, burst and len.
  - The tracker stays busy until the W beat with w_last is handshaken.
- W beat, in the order below:
  - mst.w_data = slv.w_data replicated MB/SB times.
  - mst.w_strb = slv.w_strb placed at lane(cur_addr), zeros elsewhere.
  - w_last and w_user pass through.
  - After each W handshake, cur_addr advances.
- Address advance per beat, in the order below:
  - FIXED: unchanged.
  - INCR: (addr & ~(2^size-1)) + 2^size.
  - WRAP: same as INCR, wrapped within the (len+1)*2^size aligned window.
- B: passed through unchanged, with no tracking.
- Read tracking uses AXI_MAX_READS slots. Each slot holds id, cur_addr, size, burst, len.
  - AR is stalled (slv.ar_ready=0, mst.ar_valid=0) when all slots are used, or when a slot already holds the same ID.
  - On AR handshake, a free slot is allocated.
- R beat:
  - The slot is found by r_id.
  - slv.r_data = mst.r_data slice at lane(slot.cur_addr).
  - id, resp, last and user pass through.
  - After each handshake the slot address advances.
  - The slot is freed on the r_last handshake.
- An R beat with no matching slot is a protocol error. Pass lane 0.

## Timing
- All channels are combinational passthrough, with zero added cycles. Only the tracker state is registered on posedge clk.
- valid/ready pass straight through, except for the AW/AR stall conditions above.
- Ready is never made dependent on a valid of the same channel in the downstream direction. This avoids combinational loops.
- While rst_n is asserted, in the order below:
  - All tracker state clears: write idle, all read slots free.
  - slv.aw_ready, slv.ar_ready, slv.w_ready and slv.r_valid are forced 0.
  - mst.aw_valid, mst.ar_valid, mst.w_valid and mst.r_ready are forced 0.
  - B passes through.
- Reset mid-burst drops all in-flight tracking; upstream must restart.
- AW handshake and the first W beat may occur in the same cycle. The lane is then computed from slv.aw_addr directly.
- Simultaneous AR allocate and R free of different slots in one cycle are both honoured.
- A freed slot is reusable in the next cycle.

## Test plan
- Single write, addr 0x18, size 2, INCR, len 0, data 0x0706050403020100, strb 0x0F:
  - mst.aw_addr is 0x18, size 2.
  - mst.w_data upper and lower halves both 0x0706050403020100.
  - w_strb is 0x0F00.
  - B OKAY returned upstream.
- INCR write, addr 0x0, size 3, len 3:
  - w_strb sequence 0x00FF, 0xFF00, 0x00FF, 0xFF00.
  - w_last only on beat 4.
- WRAP read, addr 0x18, size 3, len 3 (window 0x00–0x1F):
  - Lanes used: 1, 0, 1, 0.
  - slv.r_data equals the matching 64-bit halves.
- Four reads with IDs 0–3 outstanding:
  - A fifth AR is stalled until one r_last completes.
  - An AR reusing an active ID is stalled.
- Interleaved R of IDs 1 and 2:
  - Each beat uses its own slot address.
  - Data lanes are correct per ID.
- Assert rst_n during a 4-beat write after beat 2:
  - Outputs go to their reset values immediately.
  - After release, a new AW at 0x8 gives w_strb 0xFF00.

Source files
------------

// File: rtl/axi_dw_upsizer_if.sv
// AXI4 bus bundle shared by the narrow and wide sides of the upsizer.
// Master drives requests and write data, Slave drives responses.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_USER_WIDTH = 8
);
  localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [5:0]                aw_atop;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0]     w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
           aw_cache, aw_prot, aw_qos, aw_region, aw_atop, aw_user,
           aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock,
           ar_cache, ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
           aw_cache, aw_prot, aw_qos, aw_region, aw_atop, aw_user,
           aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock,
           ar_cache, ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_dw_upsizer.sv
// AXI4 narrow-to-wide data width upsizer: lane steering only, no merging.
// Only the write tracker and read slots are registered.
module axi_dw_upsizer #(
  parameter int unsigned AXI_MAX_READS           = 4,
  parameter int unsigned AXI_ADDR_WIDTH          = 64,
  parameter int unsigned AXI_ID_WIDTH            = 4,
  parameter int unsigned AXI_SLV_PORT_DATA_WIDTH = 64,
  parameter int unsigned AXI_MST_PORT_DATA_WIDTH = 128,
  parameter int unsigned AXI_USER_WIDTH          = 8
) (
  input logic    clk,
  input logic    rst_n,
  AXI_BUS.Slave  slv,
  AXI_BUS.Master mst
);
  localparam int unsigned DWS   = AXI_SLV_PORT_DATA_WIDTH;
  localparam int unsigned SB    = DWS / 8;
  localparam int unsigned MB    = AXI_MST_PORT_DATA_WIDTH / 8;
  localparam int unsigned RATIO = MB / SB;
  localparam int unsigned SOFF  = $clog2(SB);
  localparam int unsigned LW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned NR    = AXI_MAX_READS;
  localparam int unsigned IW    = (NR > 1) ? $clog2(NR) : 1;

  typedef logic [AXI_ADDR_WIDTH-1:0] addr_t;
  typedef logic [AXI_ID_WIDTH-1:0]   id_t;
  typedef logic [LW-1:0]             lane_t;
  typedef logic [IW-1:0]             idx_t;

  function automatic lane_t lane_of(input addr_t a);
    lane_of = lane_t'(a >> SOFF);
  endfunction

  function automatic addr_t next_addr(
    input addr_t       a,
    input logic [2:0]  size,
    input logic [1:0]  burst,
    input logic [7:0]  len
  );
    addr_t bytes, incr, win, base;
    bytes = addr_t'(1) << size;
    incr  = (a & ~(bytes - addr_t'(1))) + bytes;
    win   = (addr_t'(len) + addr_t'(1)) << size;
    base  = a & ~(win - addr_t'(1));
    unique case (burst)
      2'b00:   next_addr = a;
      2'b10:   next_addr = base | (incr & (win - addr_t'(1)));
      default: next_addr = incr;
    endcase
  endfunction

  // ---------------- AW / W / B ----------------
  logic       w_busy_q, w_busy_d;
  addr_t      w_addr_q, w_addr_d;
  logic [2:0] w_size_q, w_size_d;
  logic [1:0] w_burst_q, w_burst_d;
  logic [7:0] w_len_q, w_len_d;

  addr_t       w_cur_addr;
  logic [2:0]  w_cur_size;
  logic [1:0]  w_cur_burst;
  logic [7:0]  w_cur_len;
  lane_t       w_lane;
  logic [MB-1:0] w_strb;
  logic        aw_hs, w_hs;

  assign mst.aw_id     = slv.aw_id;
  assign mst.aw_addr   = slv.aw_addr;
  assign mst.aw_len    = slv.aw_len;
  assign mst.aw_size   = slv.aw_size;
  assign mst.aw_burst  = slv.aw_burst;
  assign mst.aw_lock   = slv.aw_lock;
  assign mst.aw_cache  = slv.aw_cache;
  assign mst.aw_prot   = slv.aw_prot;
  assign mst.aw_qos    = slv.aw_qos;
  assign mst.aw_region = slv.aw_region;
  assign mst.aw_atop   = slv.aw_atop;
  assign mst.aw_user   = slv.aw_user;
  assign mst.aw_valid  = ~rst_n & ~w_busy_q & slv.aw_valid;
  assign slv.aw_ready  = ~rst_n & ~w_busy_q & mst.aw_ready;
  assign aw_hs         = mst.aw_valid & mst.aw_ready;

  assign mst.w_data  = {RATIO{slv.w_data}};
  assign mst.w_strb  = w_strb;
  assign mst.w_last  = slv.w_last;
  assign mst.w_user  = slv.w_user;
  assign mst.w_valid = ~rst_n & slv.w_valid;
  assign slv.w_ready = ~rst_n & mst.w_ready;
  assign w_hs        = mst.w_valid & mst.w_ready;

  assign slv.b_id    = mst.b_id;
  assign slv.b_resp  = mst.b_resp;
  assign slv.b_user  = mst.b_user;
  assign slv.b_valid = mst.b_valid;
  assign mst.b_ready = slv.b_ready;

  // While idle, a beat arriving with its AW uses the fresh AW fields.
  always_comb begin
    w_cur_addr  = w_busy_q ? w_addr_q  : slv.aw_addr;
    w_cur_size  = w_busy_q ? w_size_q  : slv.aw_size;
    w_cur_burst = w_busy_q ? w_burst_q : slv.aw_burst;
    w_cur_len   = w_busy_q ? w_len_q   : slv.aw_len;
    w_lane      = lane_of(w_cur_addr);
    w_strb      = '0;
    w_strb[w_lane*SB +: SB] = slv.w_strb;
  end

  always_comb begin
    w_busy_d  = w_busy_q;
    w_addr_d  = w_addr_q;
    w_size_d  = w_size_q;
    w_burst_d = w_burst_q;
    w_len_d   = w_len_q;
    if (aw_hs) begin
      w_busy_d  = 1'b1;
      w_addr_d  = slv.aw_addr;
      w_size_d  = slv.aw_size;
      w_burst_d = slv.aw_burst;
      w_len_d   = slv.aw_len;
    end
    if (w_hs && (w_busy_q || aw_hs)) begin
      w_addr_d = next_addr(w_cur_addr, w_cur_size,
                           w_cur_burst, w_cur_len);
      if (slv.w_last) w_busy_d = 1'b0;
    end
  end

  // ---------------- AR / R ----------------
  logic [NR-1:0] rd_vld_q, rd_vld_d;
  id_t           rd_id_q [NR];
  id_t           rd_id_d [NR];
  addr_t         rd_addr_q [NR];
  addr_t         rd_addr_d [NR];
  logic [2:0]    rd_size_q [NR];
  logic [2:0]    rd_size_d [NR];
  logic [1:0]    rd_burst_q [NR];
  logic [1:0]    rd_burst_d [NR];
  logic [7:0]    rd_len_q [NR];
  logic [7:0]    rd_len_d [NR];

  logic  r_hit, ar_dup, ar_stall, ar_hs, r_hs;
  idx_t  r_idx, free_idx;
  lane_t r_lane;

  always_comb begin
    r_hit    = 1'b0;
    r_idx    = '0;
    ar_dup   = 1'b0;
    free_idx = '0;
    for (int i = NR - 1; i >= 0; i--) begin
      if (rd_vld_q[i] && rd_id_q[i] == mst.r_id) begin
        r_hit = 1'b1;
        r_idx = idx_t'(i);
      end
      if (rd_vld_q[i] && rd_id_q[i] == slv.ar_id) ar_dup = 1'b1;
      if (!rd_vld_q[i]) free_idx = idx_t'(i);
    end
    ar_stall = ar_dup | (&rd_vld_q);
    r_lane   = r_hit ? lane_of(rd_addr_q[r_idx]) : '0;
  end

  assign mst.ar_id     = slv.ar_id;
  assign mst.ar_addr   = slv.ar_addr;
  assign mst.ar_len    = slv.ar_len;
  assign mst.ar_size   = slv.ar_size;
  assign mst.ar_burst  = slv.ar_burst;
  assign mst.ar_lock   = slv.ar_lock;
  assign mst.ar_cache  = slv.ar_cache;
  assign mst.ar_prot   = slv.ar_prot;
  assign mst.ar_qos    = slv.ar_qos;
  assign mst.ar_region = slv.ar_region;
  assign mst.ar_user   = slv.ar_user;
  assign mst.ar_valid  = ~rst_n & slv.ar_valid & ~ar_stall;
  assign slv.ar_ready  = ~rst_n & mst.ar_ready & ~ar_stall;
  assign ar_hs         = mst.ar_valid & mst.ar_ready;

  assign slv.r_id    = mst.r_id;
  assign slv.r_data  = mst.r_data[r_lane*DWS +: DWS];
  assign slv.r_resp  = mst.r_resp;
  assign slv.r_last  = mst.r_last;
  assign slv.r_user  = mst.r_user;
  assign slv.r_valid = ~rst_n & mst.r_valid;
  assign mst.r_ready = ~rst_n & slv.r_ready;
  assign r_hs        = mst.r_valid & mst.r_ready;

  // Free and allocate never collide: allocation takes a slot free now.
  always_comb begin
    rd_vld_d   = rd_vld_q;
    rd_id_d    = rd_id_q;
    rd_addr_d  = rd_addr_q;
    rd_size_d  = rd_size_q;
    rd_burst_d = rd_burst_q;
    rd_len_d   = rd_len_q;
    if (r_hs && r_hit) begin
      rd_addr_d[r_idx] = next_addr(rd_addr_q[r_idx],
        rd_size_q[r_idx], rd_burst_q[r_idx], rd_len_q[r_idx]);
      if (mst.r_last) rd_vld_d[r_idx] = 1'b0;
    end
    if (ar_hs) begin
      rd_vld_d[free_idx]   = 1'b1;
      rd_id_d[free_idx]    = slv.ar_id;
      rd_addr_d[free_idx]  = slv.ar_addr;
      rd_size_d[free_idx]  = slv.ar_size;
      rd_burst_d[free_idx] = slv.ar_burst;
      rd_len_d[free_idx]   = slv.ar_len;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      w_busy_q  <= 1'b0;
      w_addr_q  <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_len_q   <= '0;
      rd_vld_q  <= '0;
      for (int i = 0; i < NR; i++) begin
        rd_id_q[i]    <= '0;
        rd_addr_q[i]  <= '0;
        rd_size_q[i]  <= '0;
        rd_burst_q[i] <= '0;
        rd_len_q[i]   <= '0;
      end
    end else begin
      w_busy_q   <= w_busy_d;
      w_addr_q   <= w_addr_d;
      w_size_q   <= w_size_d;
      w_burst_q  <= w_burst_d;
      w_len_q    <= w_len_d;
      rd_vld_q   <= rd_vld_d;
      rd_id_q    <= rd_id_d;
      rd_addr_q  <= rd_addr_d;
      rd_size_q  <= rd_size_d;
      rd_burst_q <= rd_burst_d;
      rd_len_q   <= rd_len_d;
    end
  end
endmodule

// File: tb/tb_axi_dw_upsizer.sv
// Randomized bench for axi_dw_upsizer against a burst-address model.
// Beat addresses are computed in closed form from start, size and index.
module tb_axi_dw_upsizer;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  AXI_BUS #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64),
            .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(8)) s ();
  AXI_BUS #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(128),
            .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(8)) m ();

  axi_dw_upsizer dut (
    .clk  (clk),
    .rst_n(rst_n),
    .slv  (s),
    .mst  (m)
  );

  // read model, indexed by ID
  bit              act [16];
  longint unsigned st  [16];
  int              sz  [16];
  int              bu  [16];
  int              ln  [16];
  int              bt  [16];
  int              nact = 0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned beat_addr(
    input longint unsigned a, input int size, input int burst,
    input int len, input int n);
    longint unsigned nb, al, win, lo;
    nb  = longint'(1) << size;
    al  = (a / nb) * nb;
    win = longint'(len + 1) * nb;
    lo  = (a / win) * win;
    if (burst == 0 || n == 0) return a;
    if (burst == 1) return al + longint'(n) * nb;
    return lo + ((al - lo) + longint'(n) * nb) % win;
  endfunction

  function automatic int lane(input longint unsigned a);
    return int'((a / 8) % 2);
  endfunction

  function automatic int rand_len(input int burst);
    if (burst == 2) return (1 << $urandom_range(1, 4)) - 1;
    return $urandom_range(0, 5);
  endfunction

  function automatic int pick_act();
    int q[$];
    for (int i = 0; i < 16; i++) if (act[i]) q.push_back(i);
    return q[$urandom_range(0, q.size() - 1)];
  endfunction

  task automatic idle();
    s.aw_valid = 0; s.w_valid = 0; s.w_last = 0;
    s.ar_valid = 0; s.b_ready = 1; s.r_ready = 1;
    m.aw_ready = 1; m.w_ready = 1; m.ar_ready = 1;
    m.b_valid = 0; m.r_valid = 0; m.r_last = 0;
  endtask

  task automatic drive_w(input logic [63:0] d, input logic [7:0] sb,
                         input bit last);
    s.w_valid = 1; s.w_data = d; s.w_strb = sb;
    s.w_last = last; s.w_user = 8'($urandom);
  endtask

  task automatic chk_w(input longint unsigned a, input int size,
                       input int burst, input int len, input int n);
    longint unsigned ba;
    logic [15:0] es;
    ba = beat_addr(a, size, burst, len, n);
    es = 16'(s.w_strb) << (lane(ba) * 8);
    chk("w_strb", m.w_strb, es);
    chk("w_data", m.w_data, {s.w_data, s.w_data});
    chk("w_last", m.w_last, s.w_last);
  endtask

  task automatic wr_burst(input longint unsigned a, input int size,
                          input int burst, input int len,
                          input bit same, input bit stalls,
                          input bit rnd, input logic [63:0] d0,
                          input logic [7:0] s0);
    int n;
    bit acc;
    @(negedge clk);
    s.aw_valid = 1; s.aw_addr = a; s.aw_size = 3'(size);
    s.aw_burst = 2'(burst); s.aw_len = 8'(len);
    s.aw_id = 4'($urandom); m.aw_ready = 1; m.w_ready = 1;
    if (same) drive_w(rnd ? 64'({$urandom, $urandom}) : d0,
                      rnd ? 8'($urandom) : s0, len == 0);
    else s.w_valid = 0;
    #1;
    chk("aw_ready", s.aw_ready, 1);
    chk("aw_addr", m.aw_addr, a);
    chk("aw_size", m.aw_size, 3'(size));
    if (same) chk_w(a, size, burst, len, 0);
    @(posedge clk);
    n = same ? 1 : 0;
    while (n <= len) begin
      @(negedge clk);
      s.aw_addr = 64'($urandom);
      drive_w(rnd ? 64'({$urandom, $urandom}) : d0,
              rnd ? 8'($urandom) : s0, n == len);
      m.w_ready = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      chk("aw_stall", s.aw_ready, 0);
      chk("w_ready", s.w_ready, m.w_ready);
      chk_w(a, size, burst, len, n);
      acc = m.w_ready;
      @(posedge clk);
      if (acc) n++;
    end
    @(negedge clk);
    s.aw_valid = 0; s.w_valid = 0; s.w_last = 0; m.w_ready = 1;
  endtask

  task automatic rd_cycle(input bit do_ar, input int aid,
                          input longint unsigned aa, input int asz,
                          input int abu, input int aln, input bit arrdy,
                          input bit do_r, input int rid,
                          input logic [127:0] rd, input bit rrdy);
    bit room;
    longint unsigned ra;
    @(negedge clk);
    s.ar_valid = do_ar; s.ar_id = 4'(aid); s.ar_addr = aa;
    s.ar_size = 3'(asz); s.ar_burst = 2'(abu); s.ar_len = 8'(aln);
    m.ar_ready = arrdy;
    m.r_valid = do_r; s.r_ready = rrdy;
    if (do_r) begin
      m.r_id = 4'(rid); m.r_data = rd; m.r_resp = 2'($urandom);
      m.r_last = (bt[rid] == ln[rid]);
    end
    #1;
    room = (nact < 4) && !act[aid];
    if (do_ar) begin
      chk("ar_ready", s.ar_ready, arrdy && room);
      chk("ar_valid", m.ar_valid, room);
      chk("ar_addr", m.ar_addr, aa);
    end
    if (do_r) begin
      ra = beat_addr(st[rid], sz[rid], bu[rid], ln[rid], bt[rid]);
      chk("r_data", s.r_data, lane(ra) ? rd[127:64] : rd[63:0]);
      chk("r_id", s.r_id, 4'(rid));
      chk("r_ready", m.r_ready, rrdy);
    end
    @(posedge clk);
    if (do_r && rrdy) begin
      if (bt[rid] == ln[rid]) begin
        act[rid] = 0; nact--;
      end else bt[rid]++;
    end
    if (do_ar && arrdy && room) begin
      act[aid] = 1; st[aid] = aa; sz[aid] = asz;
      bu[aid] = abu; ln[aid] = aln; bt[aid] = 0; nact++;
    end
  endtask

  task automatic ar_only(input int id, input longint unsigned a,
                         input int size, input int burst, input int len);
    rd_cycle(1, id, a, size, burst, len, 1, 0, 0, '0, 1);
  endtask

  task automatic r_only(input int id, input bit rrdy);
    rd_cycle(0, 0, 0, 0, 0, 0, 1, 1, id,
             {$urandom, $urandom, $urandom, $urandom}, rrdy);
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && nact > 0; k++) r_only(pick_act(), 1);
    chk("drained", 32'(nact), 0);
  endtask

  initial begin
    int bur, sze, len;
    longint unsigned a;
    s.aw_lock = 0; s.aw_cache = 0; s.aw_prot = 0; s.aw_qos = 0;
    s.aw_region = 0; s.aw_atop = 0; s.aw_user = 0;
    s.ar_lock = 0; s.ar_cache = 0; s.ar_prot = 0; s.ar_qos = 0;
    s.ar_region = 0; s.ar_user = 0; s.w_user = 0;
    s.aw_id = 0; s.aw_addr = 0; s.aw_len = 0; s.aw_size = 0;
    s.aw_burst = 0; s.w_data = 0; s.w_strb = 0;
    s.ar_id = 0; s.ar_addr = 0; s.ar_len = 0; s.ar_size = 0;
    s.ar_burst = 0;
    m.b_id = 0; m.b_resp = 0; m.b_user = 0;
    m.r_id = 0; m.r_data = 0; m.r_resp = 0; m.r_user = 0;
    idle();

    // reset: handshakes blocked, B still passes
    rst_n = 1;
    s.aw_valid = 1; s.w_valid = 1; s.ar_valid = 1;
    m.r_valid = 1; m.b_valid = 1; m.b_resp = 2'b10;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_aw_ready", s.aw_ready, 0);
    chk("rst_ar_ready", s.ar_ready, 0);
    chk("rst_w_ready", s.w_ready, 0);
    chk("rst_r_valid", s.r_valid, 0);
    chk("rst_aw_valid", m.aw_valid, 0);
    chk("rst_ar_valid", m.ar_valid, 0);
    chk("rst_w_valid", m.w_valid, 0);
    chk("rst_r_ready", m.r_ready, 0);
    chk("rst_b_valid", s.b_valid, 1);
    chk("rst_b_resp", s.b_resp, 2'b10);
    @(negedge clk);
    idle(); m.b_resp = 0;
    rst_n = 0;

    // single narrow write into the upper lane, then B
    wr_burst(64'h18, 2, 1, 0, 1, 0, 0, 64'h0706050403020100, 8'h0F);
    @(negedge clk);
    m.b_valid = 1; m.b_id = 4'd3; m.b_resp = 2'b00;
    #1;
    chk("b_valid", s.b_valid, 1);
    chk("b_id", s.b_id, 4'd3);
    chk("b_resp", s.b_resp, 2'b00);
    chk("b_ready", m.b_ready, 1);
    @(negedge clk);
    m.b_valid = 0;

    // INCR 4-beat, AW ahead of W
    wr_burst(64'h0, 3, 1, 3, 0, 0, 0, 64'h1122334455667788, 8'hFF);

    for (int i = 0; i < 40; i++) begin
      bur = $urandom_range(0, 2);
      sze = $urandom_range(0, 3);
      len = rand_len(bur);
      a = longint'($urandom_range(0, 16'hFFFF));
      if (bur == 2) a = (a >> sze) << sze;
      wr_burst(a, sze, bur, len, 1'($urandom), 1, 1, '0, '0);
    end

    // WRAP read from 0x18: lanes 1,0,1,0
    ar_only(5, 64'h18, 3, 2, 3);
    repeat (4) r_only(5, 1);

    // four outstanding, fifth and duplicate ID stall
    for (int i = 0; i < 4; i++) ar_only(i, 64'(i * 8), 3, 1, 1);
    ar_only(4, 64'h40, 3, 1, 0);
    ar_only(2, 64'h40, 3, 1, 0);
    r_only(0, 1);
    rd_cycle(1, 4, 64'h48, 3, 1, 0, 1, 1, 0,
             {$urandom, $urandom, $urandom, $urandom}, 1);
    ar_only(4, 64'h48, 3, 1, 0);

    // interleaved R of IDs 1 and 2
    for (int k = 0; k < 2; k++) begin
      r_only(1, 1);
      r_only(2, 1);
    end
    drain();

    // random AR / R traffic, alloc and free often coincide
    for (int i = 0; i < 300; i++) begin
      bit dar, dr;
      bur = $urandom_range(0, 2);
      sze = $urandom_range(0, 3);
      len = rand_len(bur);
      a = longint'($urandom_range(0, 16'hFFFF));
      if (bur == 2) a = (a >> sze) << sze;
      dar = ($urandom_range(0, 2) != 0);
      dr = (nact > 0) && ($urandom_range(0, 3) != 0);
      rd_cycle(dar, $urandom_range(0, 7), a, sze, bur, len,
               $urandom_range(0, 3) != 0, dr, dr ? pick_act() : 0,
               {$urandom, $urandom, $urandom, $urandom},
               $urandom_range(0, 3) != 0);
    end
    drain();

    // reset in the middle of a 4-beat write
    @(negedge clk);
    s.aw_valid = 1; s.aw_addr = 64'h0; s.aw_size = 3'd3;
    s.aw_burst = 2'd1; s.aw_len = 8'd3;
    drive_w(64'hA5A5, 8'hFF, 0);
    @(posedge clk);
    @(negedge clk);
    s.aw_valid = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    s.aw_valid = 1; s.ar_valid = 1; m.r_valid = 1;
    #1;
    chk("mid_w_ready", s.w_ready, 0);
    chk("mid_w_valid", m.w_valid, 0);
    chk("mid_aw_ready", s.aw_ready, 0);
    chk("mid_aw_valid", m.aw_valid, 0);
    chk("mid_ar_ready", s.ar_ready, 0);
    chk("mid_r_valid", s.r_valid, 0);
    @(posedge clk);
    @(negedge clk);
    idle();
    rst_n = 0;
    wr_burst(64'h8, 3, 1, 0, 1, 0, 0, 64'hDEADBEEF, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
